// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states
// and ID register layout.
package irq_ctrl_pkg;

  localparam int DATA_W       = 32;
  localparam int IDX_W        = 3;
  localparam int ID_VALID_BIT = 31;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_ID   = 2'd2;
  localparam logic [1:0] OFF_ACK  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scanning from the top down lets the lowest set bit overwrite the result last.
  always_comb begin
    // NOTE: default assignment first so no path leaves idx_o unassigned (no latch).
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with PEND/MASK/ID/ACK registers and a
// registered irq line. Define IRQ_CTRL_EDGE_EN for rising-edge source detection
// (default build is level-sensitive).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      src,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              irq
);

  irq_state_e       state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [IDX_W-1:0] isv_q, isv_d;
  logic             irq_q, irq_d;

  logic [N-1:0]     set_vec;
  logic [N-1:0]     w1c_clr;
  logic [N-1:0]     ack_clr;
  logic [IDX_W-1:0] prio_idx;
  logic             prio_valid;
  logic             bus_wr;
  logic             id_read;
  logic             ack_hit;
  logic             unused_wd;

  assign bus_wr    = sel && we;
  assign id_read   = sel && !we && (addr == OFF_ID);
  assign ack_hit   = bus_wr && (addr == OFF_ACK) && (state_q == ST_SERVICE)
                     && (wd[IDX_W-1:0] == isv_q);
  assign unused_wd = ^wd;

`ifdef IRQ_CTRL_EDGE_EN
  logic [N-1:0] src_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) src_prev_q <= '0;
    else      src_prev_q <= src;
  end

  assign set_vec = src & ~src_prev_q;
`else
  assign set_vec = src;
`endif

  irq_prio_enc #(.N(N)) u_prio (
    .req_i   (pend_q & mask_q),
    .idx_o   (prio_idx),
    .valid_o (prio_valid)
  );

  // Set is OR-ed in last so a coincident source request beats any clear.
  always_comb begin
    w1c_clr = (bus_wr && (addr == OFF_PEND)) ? wd[N-1:0] : '0;
    ack_clr = '0;
    for (int i = 0; i < N; i++) begin
      ack_clr[i] = ack_hit && (isv_q == IDX_W'(i));
    end
    pend_d = (pend_q & ~w1c_clr & ~ack_clr) | set_vec;
    mask_d = (bus_wr && (addr == OFF_MASK)) ? wd[N-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      isv_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      isv_q   <= isv_d;
      irq_q   <= irq_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    isv_d   = isv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (prio_valid) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (id_read && prio_valid) begin
          state_d = ST_SERVICE;
          isv_d   = prio_idx;
        end else if (!prio_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (ack_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: output logic, registered so irq tracks ASSERT without a comb path.
  always_comb begin
    irq_d = (state_d == ST_ASSERT);
  end

  assign irq = irq_q;

  always_comb begin
    rd = '0;
    unique case (addr)
      OFF_PEND: rd[N-1:0] = pend_q;
      OFF_MASK: rd[N-1:0] = mask_q;
      OFF_ID: begin
        rd[ID_VALID_BIT] = prio_valid;
        rd[IDX_W-1:0]    = prio_idx;
      end
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by randomized
// bus/source traffic compared against an integer-level reference model.
module tb_irq_ctrl;

  localparam int N     = 4;
  localparam int NMASK = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src;
  logic          sel;
  logic          we;
  logic [1:0]    addr;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic          irq;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = quiet, 1 = waiting for the core, 2 = in service.
  int m_pend, m_mask, m_phase, m_isv, m_prev;

  irq_ctrl #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .src  (src),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_rd(input int a);
    int m;
    m = m_pend & m_mask;
    case (a)
      0: return 32'(m_pend);
      1: return 32'(m_mask);
      2: return (m != 0) ? (32'h8000_0000 | 32'(lowest(m))) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_phase = 0; m_isv = 0; m_prev = 0;
  endtask

  task automatic model_edge();
    int  masked, lo, set, np;
    bit  v, wr, ack_ok;
    masked = m_pend & m_mask;
    v      = (masked != 0);
    lo     = lowest(masked);
    wr     = sel && we;
    ack_ok = wr && (addr == 2'd3) && (m_phase == 2) && (int'(wd[2:0]) == m_isv);
`ifdef IRQ_CTRL_EDGE_EN
    set = int'(src) & ~m_prev;
`else
    set = int'(src);
`endif
    m_prev = int'(src);
    np = m_pend;
    if (wr && addr == 2'd0) np &= ~int'(wd[N-1:0]);
    if (ack_ok) np &= ~(1 << m_isv);
    np |= set;
    if (wr && addr == 2'd1) m_mask = int'(wd[N-1:0]);
    case (m_phase)
      0: if (v) m_phase = 1;
      1: begin
        if (sel && !we && addr == 2'd2 && v) begin
          m_phase = 2;
          m_isv   = lo;
        end else if (!v) begin
          m_phase = 0;
        end
      end
      default: if (ack_ok) m_phase = 0;
    endcase
    m_pend = np;
  endtask

  task automatic idle_bus();
    sel = 1'b0; we = 1'b0; addr = 2'd0; wd = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("irq_model", {31'h0, irq}, {31'h0, m_phase == 1});
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sel = 1'b0; we = 1'b0; addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wd = d;
    step();
    idle_bus();
  endtask

  task automatic bus_read_id();
    sel = 1'b1; we = 1'b0; addr = 2'd2; wd = 32'h0;
    step();
    idle_bus();
  endtask

  initial begin
    rst = 1'b0;
    src = '0;
    idle_bus();
    model_reset();
    #12;
    check("rst_irq", {31'h0, irq}, 32'h0);
    peek("rst_pend", 2'd0, 32'h0);
    peek("rst_id", 2'd2, 32'h0);
    rst = 1'b1;
    step();

    // MASK=5, one-cycle pulse on src[2]
    bus_write(2'd1, 32'h5);
    src = 4'h4;
    step();
    src = '0;
    peek("s1_pend", 2'd0, 32'h4);
    check("s1_irq_lo", {31'h0, irq}, 32'h0);
    step();
    check("s1_irq_hi", {31'h0, irq}, 32'h1);
    peek("s1_id", 2'd2, 32'h8000_0002);

    // ID read then matching ACK
    bus_read_id();
    check("s2_irq_svc", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'h2);
    peek("s2_pend", 2'd0, 32'h0);
    step();
    check("s2_irq_idle", {31'h0, irq}, 32'h0);

    // Two pending sources: lowest index served first
    bus_write(2'd1, 32'hF);
    src = 4'h5;
    step();
    src = '0;
    step();
    peek("s3_id0", 2'd2, 32'h8000_0000);
    bus_read_id();
    bus_write(2'd3, 32'h0);
    peek("s3_pend", 2'd0, 32'h4);
    step();
    check("s3_irq_re", {31'h0, irq}, 32'h1);
    peek("s3_id2", 2'd2, 32'h8000_0002);
    bus_read_id();
    bus_write(2'd3, 32'h2);

    // Mismatched ACK in SERVICE is ignored
    src = 4'h2;
    step();
    src = '0;
    step();
    bus_read_id();
    bus_write(2'd3, 32'h3);
    peek("s4_pend", 2'd0, 32'h2);
    step();
    step();
    check("s4_irq_hold", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'h1);
    peek("s4_pend_ack", 2'd0, 32'h0);

    // W1C coincident with a fresh src[1] request: set wins
    src = 4'h2;
    step();
    src = '0;
    step();
    src = 4'h2;
    sel = 1'b1; we = 1'b1; addr = 2'd0; wd = 32'h2;
    step();
    idle_bus();
    src = '0;
    peek("s5_pend", 2'd0, 32'h2);

    // Reset mid-SERVICE acts without a clock edge
    step();
    bus_read_id();
    peek("s6_pre_mask", 2'd1, 32'hF);
    rst = 1'b0;
    #1;
    model_reset();
    check("s6_irq", {31'h0, irq}, 32'h0);
    peek("s6_pend", 2'd0, 32'h0);
    peek("s6_mask", 2'd1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 800; cyc++) begin
      int r;
      src = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        sel = 1'b1; we = 1'b1; addr = 2'd0; wd = $urandom;
      end else if (r < 3) begin
        sel = 1'b1; we = 1'b1; addr = 2'd1; wd = $urandom;
      end else if (r < 5) begin
        sel = 1'b1; we = 1'b0; addr = 2'd2; wd = $urandom;
      end else if (r < 7) begin
        sel = 1'b1; we = 1'b1; addr = 2'd3;
        wd = ($urandom_range(0, 1) == 0) ? 32'(m_isv) : 32'($urandom_range(0, 7));
      end else begin
        sel = 1'($urandom); we = 1'b0; addr = 2'($urandom); wd = $urandom;
      end
      #1;
      check("rand_rd", rd, model_rd(int'(addr)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
